// File: rtl/uart_pkg.sv
// Shared definitions for the x16-oversampled 8N1 UART blocks.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        START = 3'd1,
        DATA  = 3'd2,
        STOP  = 3'd3,
        BREAK = 3'd4
    } state_t;

    localparam int OVERSAMPLE = 16;
    localparam int MID_SAMPLE = 7;

    // Clocks per oversample tick; truncation only shifts the sample point slightly.
    function automatic int calc_div(input int clk_freq, input int baud);
        return clk_freq / (baud * OVERSAMPLE);
    endfunction

endpackage

// File: rtl/uart_rx_8n1_if.sv
// Byte-level side of the receiver: serial pin in, rdy/rdy_clr byte handshake out.
// rdy is a level: it stays high while dout holds a byte nobody has taken; the consumer
// pulses rdy_clr for one clock to take it. A byte completing in the same clock wins.
interface uart_rx_8n1_if;
    logic       rx;
    logic       rdy_clr;
    logic       rdy;
    logic [7:0] dout;
    logic       frame_err;
    logic       overrun;

    modport master (
        output rx, rdy_clr,
        input  rdy, dout, frame_err, overrun
    );

    modport slave (
        input  rx, rdy_clr,
        output rdy, dout, frame_err, overrun
    );
endinterface

// File: rtl/uart_baud_tick.sv
// Free-running divide-by-DIV tick generator with a synchronous phase clear.
module uart_baud_tick #(
    parameter int DIV = 27
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_clr,
    output logic o_tick
);
    localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;

    logic [CW-1:0] r_cnt;

    assign o_tick = (r_cnt == CW'(DIV - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (i_clr || o_tick) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + CW'(1);
        end
    end
endmodule

// File: rtl/uart_rx_8n1.sv
// 8N1 UART receiver: 2-FF synchroniser, x16 oversampling FSM, level rdy/rdy_clr output.
module uart_rx_8n1
    import uart_pkg::*;
#(
    parameter int CLK_FREQ = 50_000_000,
    parameter int BAUD     = 115200
) (
    input  logic              clk,
    input  logic              rst_n,
    uart_rx_8n1_if.slave      bus,
    output state_t            o_state
);
    localparam int DIV = calc_div(CLK_FREQ, BAUD);

    logic [1:0] r_sync;
    logic       r_rxs_d;
    logic       w_rxs;
    logic       w_tick;

    state_t     r_state, w_state_nxt;
    logic [3:0] r_scnt, w_scnt_nxt;
    logic [2:0] r_bit, w_bit_nxt;
    logic [7:0] r_shift, w_shift_nxt;
    logic       w_tick_clr;
    logic       w_done;
    logic       w_ferr;
    logic       w_mid_start;
    logic       w_mid_bit;

    logic       r_rdy;
    logic [7:0] r_dout;
    logic       r_ferr;
    logic       r_ovr;

    assign w_rxs = r_sync[1];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync  <= 2'b11;
            r_rxs_d <= 1'b1;
        end else begin
            r_sync  <= {r_sync[0], bus.rx};
            r_rxs_d <= w_rxs;
        end
    end

    uart_baud_tick #(.DIV(DIV)) u_tick (
        .clk    (clk),
        .rst_n  (rst_n),
        .i_clr  (w_tick_clr),
        .o_tick (w_tick)
    );

    // START samples half a bit after the edge; later bits every full 16 ticks.
    assign w_mid_start = w_tick && (r_scnt == 4'(MID_SAMPLE));
    assign w_mid_bit   = w_tick && (r_scnt == 4'(OVERSAMPLE - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_scnt  <= '0;
            r_bit   <= '0;
            r_shift <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_scnt  <= w_scnt_nxt;
            r_bit   <= w_bit_nxt;
            r_shift <= w_shift_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_scnt_nxt  = w_tick ? r_scnt + 4'd1 : r_scnt;
        w_bit_nxt   = r_bit;
        w_shift_nxt = r_shift;
        w_tick_clr  = 1'b0;
        w_done      = 1'b0;
        w_ferr      = 1'b0;
        case (r_state)
            IDLE: begin
                if (r_rxs_d && !w_rxs) begin
                    w_tick_clr  = 1'b1;
                    w_scnt_nxt  = '0;
                    w_bit_nxt   = '0;
                    w_state_nxt = START;
                end
            end
            START: begin
                if (w_mid_start) begin
                    w_scnt_nxt  = '0;
                    w_bit_nxt   = '0;
                    w_state_nxt = w_rxs ? IDLE : DATA;
                end
            end
            DATA: begin
                if (w_mid_bit) begin
                    w_shift_nxt = {w_rxs, r_shift[7:1]};
                    w_bit_nxt   = r_bit + 3'd1;
                    if (r_bit == 3'd7) begin
                        w_state_nxt = STOP;
                    end
                end
            end
            STOP: begin
                if (w_mid_bit) begin
                    if (w_rxs) begin
                        w_done      = 1'b1;
                        w_state_nxt = IDLE;
                    end else begin
                        w_ferr      = 1'b1;
                        w_state_nxt = BREAK;
                    end
                end
            end
            BREAK: begin
                if (w_rxs) begin
                    w_state_nxt = IDLE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    // A completing byte takes priority over a coincident rdy_clr.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rdy  <= 1'b0;
            r_dout <= 8'h00;
            r_ferr <= 1'b0;
            r_ovr  <= 1'b0;
        end else begin
            if (w_done) begin
                r_rdy  <= 1'b1;
                r_dout <= r_shift;
            end else if (bus.rdy_clr) begin
                r_rdy <= 1'b0;
            end
            r_ferr <= w_ferr;
            r_ovr  <= w_done && r_rdy && !bus.rdy_clr;
        end
    end

    assign bus.rdy       = r_rdy;
    assign bus.dout      = r_dout;
    assign bus.frame_err = r_ferr;
    assign bus.overrun   = r_ovr;
    assign o_state       = r_state;
endmodule

// File: tb/tb_uart_rx_8n1.sv
// Bench for uart_rx_8n1: byte scoreboard, vector table and hand-written corner sequences.
module tb_uart_rx_8n1;
    import uart_pkg::*;

    localparam int BIT_CLK = 432;   // 16 * (50 MHz / (115200 * 16)) clocks per bit

    typedef struct {
        logic [7:0] data;
        logic       stop_ok;
        logic       exp_rdy;
        logic [7:0] exp_dout;
        int         exp_ferr;
    } vec_t;

    // ---------------- clock / reset ----------------
    logic   clk   = 1'b0;
    logic   rst_n = 1'b0;
    int     cyc   = 0;
    state_t state;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    uart_rx_8n1_if bus ();

    uart_rx_8n1 dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .bus     (bus),
        .o_state (state)
    );

    // ---------------- counters / checks ----------------
    int n_tests  = 0;
    int n_fail   = 0;
    int ferr_cnt = 0;
    int ovr_cnt  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic check_range(input string name, input int act, input int lo, input int hi);
        n_tests++;
        if (act < lo || act > hi) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d..%0d", name, act, lo, hi);
        end
    endtask

    // ---------------- scoreboard ----------------
    logic [7:0] exp_q[$];
    logic       rdy_q = 1'b0;

    always @(negedge clk) begin
        logic [7:0] e;
        if (!rst_n) begin
            rdy_q = 1'b0;
        end else begin
            if (bus.frame_err) ferr_cnt++;
            if (bus.overrun)   ovr_cnt++;
            if ((bus.rdy && !rdy_q) || bus.overrun) begin
                if (exp_q.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL sb_unexpected: got dout=%0h, expected no new byte", bus.dout);
                end else begin
                    e = exp_q.pop_front();
                    check("sb_dout", {24'h0, bus.dout}, {24'h0, e});
                end
            end
            rdy_q = bus.rdy;
        end
    end

    // ---------------- drivers ----------------
    task automatic idle_clks(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic send_frame(input logic [7:0] data, input logic stop);
        bus.rx = 1'b0;
        idle_clks(BIT_CLK);
        for (int i = 0; i < 8; i++) begin
            bus.rx = data[i];
            idle_clks(BIT_CLK);
        end
        bus.rx = stop;
        idle_clks(BIT_CLK);
    endtask

    task automatic pulse_clr();
        bus.rdy_clr = 1'b1;
        @(negedge clk);
        bus.rdy_clr = 1'b0;
    endtask

    task automatic wait_rdy(input int max_clks, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < max_clks; i++) begin
            if (bus.rdy) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        if (!ok) begin
            n_tests++;
            n_fail++;
            $display("FAIL rdy_timeout: got rdy=0 after %0d clocks, expected rdy=1", max_clks);
        end
    endtask

    // ---------------- watchdog ----------------
    initial begin
        #(10 * 98000);
        $display("FAIL watchdog: got no completion, expected finish within 98000 clocks");
        $fatal(1, "watchdog");
    end

    // ---------------- test sequence ----------------
    vec_t vecs[4];

    initial begin
        int t0;
        int lat;
        int f0;
        int o0;
        bit ok;

        vecs[0] = '{data: 8'h00, stop_ok: 1'b1, exp_rdy: 1'b1, exp_dout: 8'h00, exp_ferr: 0};
        vecs[1] = '{data: 8'hFF, stop_ok: 1'b1, exp_rdy: 1'b1, exp_dout: 8'hFF, exp_ferr: 0};
        vecs[2] = '{data: 8'h5A, stop_ok: 1'b0, exp_rdy: 1'b0, exp_dout: 8'hFF, exp_ferr: 1};
        vecs[3] = '{data: 8'hC3, stop_ok: 1'b1, exp_rdy: 1'b1, exp_dout: 8'hC3, exp_ferr: 0};
        lat = 4107;

        bus.rx      = 1'b1;
        bus.rdy_clr = 1'b0;
        idle_clks(5);
        check("rst_rdy",   {31'h0, bus.rdy},       32'h0);
        check("rst_dout",  {24'h0, bus.dout},      32'h0);
        check("rst_ferr",  {31'h0, bus.frame_err}, 32'h0);
        check("rst_ovr",   {31'h0, bus.overrun},   32'h0);
        check("rst_state", 32'(state),             32'(IDLE));
        rst_n = 1'b1;
        idle_clks(20);

        // glitch: short low pulse must not start a frame
        bus.rx = 1'b0;
        idle_clks(100);
        bus.rx = 1'b1;
        idle_clks(400);
        check("glitch_rdy",   {31'h0, bus.rdy},  32'h0);
        check("glitch_dout",  {24'h0, bus.dout}, 32'h0);
        check("glitch_state", 32'(state),        32'(IDLE));

        // framing error with line held low for three bit times
        f0 = ferr_cnt;
        send_frame(8'hA3, 1'b0);
        idle_clks(2 * BIT_CLK);
        check("ferr_break_state", 32'(state), 32'(BREAK));
        bus.rx = 1'b1;
        idle_clks(2 * BIT_CLK);
        check("ferr_pulses", ferr_cnt - f0,     32'd1);
        check("ferr_rdy",    {31'h0, bus.rdy},  32'h0);
        check("ferr_dout",   {24'h0, bus.dout}, 32'h0);
        check("ferr_state",  32'(state),        32'(IDLE));
        exp_q.push_back(8'h3C);
        send_frame(8'h3C, 1'b1);
        check("after_ferr_rdy",  {31'h0, bus.rdy},  32'h1);
        check("after_ferr_dout", {24'h0, bus.dout}, 32'h3C);
        pulse_clr();

        // single frame with latency measurement and delayed rdy_clr
        idle_clks(50);
        exp_q.push_back(8'h55);
        t0 = cyc;
        fork
            send_frame(8'h55, 1'b1);
            begin
                wait_rdy(5000, ok);
                if (ok) begin
                    lat = cyc - t0;
                    check_range("single_latency", lat, 4100, 4112);
                    idle_clks(10);
                    check("single_rdy_held", {31'h0, bus.rdy},  32'h1);
                    check("single_dout",     {24'h0, bus.dout}, 32'h55);
                    pulse_clr();
                    check("single_rdy_clr",  {31'h0, bus.rdy},  32'h0);
                end
            end
        join
        check("single_ferr", ferr_cnt, 32'd0 + f0 + 1);
        check("single_ovr",  ovr_cnt,  32'd0);

        // vector table
        foreach (vecs[i]) begin
            f0 = ferr_cnt;
            if (vecs[i].stop_ok) exp_q.push_back(vecs[i].data);
            send_frame(vecs[i].data, vecs[i].stop_ok);
            if (!vecs[i].stop_ok) begin
                idle_clks(BIT_CLK);
                bus.rx = 1'b1;
            end
            idle_clks(20);
            check($sformatf("vec%0d_rdy", i),  {31'h0, bus.rdy},  {31'h0, vecs[i].exp_rdy});
            check($sformatf("vec%0d_dout", i), {24'h0, bus.dout}, {24'h0, vecs[i].exp_dout});
            check($sformatf("vec%0d_ferr", i), ferr_cnt - f0,     vecs[i].exp_ferr);
            pulse_clr();
            check($sformatf("vec%0d_clr", i),  {31'h0, bus.rdy},  32'h0);
        end

        // overrun: two back-to-back bytes without rdy_clr
        o0 = ovr_cnt;
        exp_q.push_back(8'h12);
        exp_q.push_back(8'h34);
        send_frame(8'h12, 1'b1);
        send_frame(8'h34, 1'b1);
        check("ovr_pulses", ovr_cnt - o0,      32'd1);
        check("ovr_dout",   {24'h0, bus.dout}, 32'h34);
        check("ovr_rdy",    {31'h0, bus.rdy},  32'h1);
        pulse_clr();

        // rdy_clr in the exact completion cycle of 0x7E
        exp_q.push_back(8'h11);
        send_frame(8'h11, 1'b1);
        o0 = ovr_cnt;
        fork
            send_frame(8'h7E, 1'b1);
            begin
                idle_clks(lat - 1);
                pulse_clr();
                check("simul_rdy_at_edge", {31'h0, bus.rdy}, 32'h1);
            end
        join
        check("simul_rdy",  {31'h0, bus.rdy},  32'h1);
        check("simul_dout", {24'h0, bus.dout}, 32'h7E);
        check("simul_ovr",  ovr_cnt - o0,      32'd0);

        // reset during data bit 4 of 0xFF
        bus.rx = 1'b0;
        idle_clks(BIT_CLK);
        bus.rx = 1'b1;
        idle_clks(4 * BIT_CLK + BIT_CLK / 2);
        rst_n = 1'b0;
        idle_clks(3);
        check("midrst_rdy",   {31'h0, bus.rdy},       32'h0);
        check("midrst_dout",  {24'h0, bus.dout},      32'h0);
        check("midrst_ferr",  {31'h0, bus.frame_err}, 32'h0);
        check("midrst_ovr",   {31'h0, bus.overrun},   32'h0);
        check("midrst_state", 32'(state),             32'(IDLE));
        rst_n = 1'b1;
        idle_clks(3 * BIT_CLK);
        check("postrst_rdy",  {31'h0, bus.rdy}, 32'h0);
        exp_q.push_back(8'h81);
        send_frame(8'h81, 1'b1);
        check("postrst_rdy_byte", {31'h0, bus.rdy},  32'h1);
        check("postrst_dout",     {24'h0, bus.dout}, 32'h81);

        idle_clks(20);
        check("sb_empty", exp_q.size(), 32'd0);

        // ---------------- report ----------------
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/uart_rx_8n1.md
Name: uart_rx_8n1

Overview:
Standalone 8N1 UART receiver for the 50 MHz board designs. It recovers bytes from the serial RX pin using a 16x oversampling tick. Each received byte is presented on a level-sensitive rdy/rdy_clr handshake, matching the existing UART data interface (rx, rdy, rdy_clr, dout). Intended to be instantiated by top-levels that act on host commands, for example key/LED control over serial.

Parameters:
CLK_FREQ, 50_000_000, system clock frequency in Hz
BAUD, 115200, line rate in bit/s
DIV, CLK_FREQ/(BAUD*16), clocks per oversample tick (derived; 27 at the defaults; integer truncation is accepted)

Ports:
clk  in  1  system clock, 50 MHz
rst_n  in  1  asynchronous active-low reset
rx  in  1  serial input, asynchronous, idle high
rdy_clr  in  1  one-cycle pulse from the consumer: byte taken, clear rdy
rdy  out  1  high while dout holds an unconsumed byte
dout  out  8  last good received byte, LSB first on the line
frame_err  out  1  one-cycle pulse when the stop bit is sampled low
overrun  out  1  one-cycle pulse when a good byte completes while rdy is still set

Behaviour:
- Reset (async assert, sync release): state=IDLE; rdy=0; dout=8'h00; frame_err=0; overrun=0; synchroniser flops=1; all counters=0.
- Synchroniser: rx passes through a 2-FF synchroniser, reset value 1. All decisions use the synchronised signal rxs.
- Tick generator: counter runs 0..DIV-1 and emits a tick when it reaches DIV-1. It is forced to 0 on start detection so the sampling phase aligns to the falling edge.
- Sample counter: scnt, 4 bits, increments on each tick and wraps 15->0.
- IDLE: on a high->low transition of rxs, clear the tick counter and scnt, then go to START.
- START: on the tick where scnt reaches 7 (mid-bit):
  - rxs=0: go to DATA with bit index 0 and scnt=0.
  - rxs=1: glitch; return to IDLE with no output change.
- DATA: every 16 ticks (scnt wraps at mid-bit), shift rxs into the shift register LSB first. After the 8th bit, go to STOP.
- STOP: sample at mid-bit.
  - rxs=1: dout<=shift register and rdy<=1 in the next clock. If rdy was already 1 and rdy_clr is not asserted in that cycle, pulse overrun; dout is still overwritten (newest data wins). Return to IDLE immediately, which permits back-to-back frames with no idle gap.
  - rxs=0: pulse frame_err; dout and rdy are unchanged. Go to BREAK.
- BREAK: wait for rxs=1, then go to IDLE. Prevents a held-low line from producing repeated frames.
- rdy_clr: clears rdy on the next clock. If it coincides with completion of a good byte, completion wins: rdy stays 1 and no overrun is flagged. rdy_clr while rdy=0 is ignored.
- Latency: rdy rises 2 sync clocks + ~9.5 bit times after the start edge, i.e. 1 clock after the mid-stop sample.
- Reset mid-frame abandons the frame: all outputs return to reset values and no partial byte appears.

Decomposition:
- Shared package uart_pkg:
  - State enum {IDLE, START, DATA, STOP, BREAK}.
  - Constant function computing DIV from CLK_FREQ and BAUD.
  - OVERSAMPLE=16 and MID_SAMPLE=7 constants.
- One natural sub-module: uart_baud_tick. It holds the DIV counter, provides a sync-clear input and a one-cycle tick output, and is reusable by a future transmitter at x16.
- The rest (synchroniser, FSM, shift register, handshake flags) lives in uart_rx_8n1.

Test Plan:
- Bit time is 432 clk at the defaults.
- Single frame: send 0x55, then rdy_clr 10 clk after rdy rises.
  - Required: dout=8'h55; rdy high from ~4105 clk after the start edge until 1 clk after rdy_clr; frame_err=0; overrun=0.
- Glitch rejection: rx low for 100 clk, then high.
  - Required: no rdy, dout stays 8'h00, FSM back in IDLE.
- Framing error: send 0xA3 with the stop bit low, holding rx low for 3 bit times.
  - Required: one frame_err pulse; rdy=0; dout=8'h00; no further frames until rx returns high.
  - Then send 0x3C: dout=8'h3C with rdy=1.
- Overrun: send 0x12 then 0x34 back-to-back with no rdy_clr.
  - Required: one overrun pulse at the second stop bit; dout=8'h34; rdy=1.
- Simultaneous: assert rdy_clr in the exact cycle a second byte 0x7E completes.
  - Required: rdy stays 1, dout=8'h7E, overrun=0.
- Reset mid-frame: assert rst_n=0 during data bit 4 of 0xFF, then release and send 0x81.
  - Required: all outputs at reset values during reset; next valid output is dout=8'h81 only.
